// File: rtl/hsv_core_pkg.sv
// rtl/hsv_core_pkg.sv - shared register-address types and dispatch FIFO pointer helpers.
package hsv_core_pkg;

  typedef logic [4:0]  reg_addr;
  typedef logic [31:0] reg_mask;

  localparam reg_addr REG_X0 = 5'd0;

  localparam int DISPATCH_PTR_W = 8;
  typedef logic [DISPATCH_PTR_W-1:0] dispatch_fifo_ptr;

  // Depth is a power of two, so wrapping is a mask rather than a compare.
  function automatic dispatch_fifo_ptr fifo_ptr_next(input dispatch_fifo_ptr p, input int depth);
    return (p + dispatch_fifo_ptr'(1)) & dispatch_fifo_ptr'(depth - 1);
  endfunction

endpackage

// File: rtl/hsv_core_dispatch_fifo.sv
// rtl/hsv_core_dispatch_fifo.sv - per-channel in-order FIFO feeding one execution unit.
module hsv_core_dispatch_fifo
  import hsv_core_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk_core,
  input  logic             rst_core,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // A full FIFO refuses a push even if the head leaves in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & out_valid;

  always_ff @(posedge clk_core) begin
    if (rst_core || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= AW'(fifo_ptr_next(dispatch_fifo_ptr'(wr_ptr), DEPTH));
      if (do_pop)  rd_ptr <= AW'(fifo_ptr_next(dispatch_fifo_ptr'(rd_ptr), DEPTH));
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_core) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hsv_core_dispatch.sv
// rtl/hsv_core_dispatch.sv - scoreboarded instruction dispatch into per-unit FIFOs.
module hsv_core_dispatch
  import hsv_core_pkg::*;
#(
  parameter  int NUM_UNITS = 4,
  parameter  int DEPTH     = 2,
  parameter  int WIDTH     = 64,
  localparam int UW        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                     clk_core,
  input  logic                     rst_core,
  input  logic                     flush_req,
  output logic                     flush_ack,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [UW-1:0]            in_unit,
  input  reg_addr                  in_rs1,
  input  reg_addr                  in_rs2,
  input  reg_addr                  in_rd,
  input  logic                     in_use_rs1,
  input  logic                     in_use_rs2,
  input  logic                     in_rd_we,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [NUM_UNITS*WIDTH-1:0] out_data,
  output logic [NUM_UNITS-1:0]     out_valid,
  input  logic [NUM_UNITS-1:0]     out_ready,
  input  reg_addr                  wb_addr,
  input  logic                     wb_en,
  output logic                     err_o
);

  localparam logic [UW:0] NUM_UNITS_W = (UW+1)'(NUM_UNITS);

  reg_mask              busy;
  reg_mask              busy_nxt;
  logic [NUM_UNITS-1:0] full;
  logic [NUM_UNITS-1:0] push;
  logic [NUM_UNITS-1:0] pop;
  logic                 full_sel;
  logic                 hazard;
  logic                 unit_ok;
  logic                 accept;

  assign unit_ok = ({1'b0, in_unit} < NUM_UNITS_W);

  assign hazard = (in_use_rs1 & busy[in_rs1])
                | (in_use_rs2 & busy[in_rs2])
                | (in_rd_we   & busy[in_rd]);

  // An out-of-range unit never matches, so it cannot be blocked by a full FIFO.
  always_comb begin
    full_sel = 1'b0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (in_unit == UW'(k)) full_sel = full[k];
    end
  end

  assign ready_o = ~flush_req & ~hazard & ~full_sel;
  assign accept  = valid_i & ready_o;

  always_comb begin
    push = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (in_unit == UW'(k)) push[k] = accept;
    end
  end

  assign pop = out_valid & out_ready & {NUM_UNITS{~flush_req}};

  // Writeback clears first so a same-cycle new writer of the register wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_en) busy_nxt[wb_addr] = 1'b0;
    if (accept && unit_ok && in_rd_we && (in_rd != REG_X0)) busy_nxt[in_rd] = 1'b1;
    busy_nxt[REG_X0] = 1'b0;
  end

  always_ff @(posedge clk_core) begin
    if (rst_core || flush_req) busy <= '0;
    else                       busy <= busy_nxt;
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      flush_ack <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      flush_ack <= flush_req;
      err_o     <= accept & ~unit_ok;
    end
  end

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unit
    hsv_core_dispatch_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_core  (clk_core),
      .rst_core  (rst_core),
      .flush     (flush_req),
      .push      (push[k]),
      .push_data (in_data),
      .pop       (pop[k]),
      .out_data  (out_data[k*WIDTH +: WIDTH]),
      .out_valid (out_valid[k]),
      .full      (full[k])
    );
  end

endmodule

// File: tb/tb_hsv_core_dispatch.sv
// tb/tb_hsv_core_dispatch.sv - directed-vector bench for hsv_core_dispatch.
module tb_hsv_core_dispatch;
  import hsv_core_pkg::*;

  logic          clk_core = 1'b0;
  logic          rst_core;
  logic          flush_req;
  logic          flush_ack;
  logic [63:0]   in_data;
  logic [1:0]    in_unit;
  reg_addr       in_rs1, in_rs2, in_rd;
  logic          in_use_rs1, in_use_rs2, in_rd_we;
  logic          valid_i;
  logic          ready_o;
  logic [255:0]  out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  reg_addr       wb_addr;
  logic          wb_en;
  logic          err_o;

  logic [1:0]    in_unit3;
  logic          valid3;
  logic          ready3;
  logic          flush_ack3;
  logic [191:0]  out_data3;
  logic [2:0]    out_valid3;
  logic          err3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_core = ~clk_core;

  hsv_core_dispatch dut (
    .clk_core(clk_core), .rst_core(rst_core), .flush_req(flush_req), .flush_ack(flush_ack),
    .in_data(in_data), .in_unit(in_unit), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_rd_we(in_rd_we),
    .valid_i(valid_i), .ready_o(ready_o), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .wb_addr(wb_addr), .wb_en(wb_en), .err_o(err_o)
  );

  hsv_core_dispatch #(.NUM_UNITS(3)) dut3 (
    .clk_core(clk_core), .rst_core(rst_core), .flush_req(flush_req), .flush_ack(flush_ack3),
    .in_data(in_data), .in_unit(in_unit3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_rd_we(in_rd_we),
    .valid_i(valid3), .ready_o(ready3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(3'b111), .wb_addr(wb_addr), .wb_en(wb_en), .err_o(err3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_core);
    #1;
  endtask

  task automatic beat(input logic [1:0] unit, input logic [63:0] d, input reg_addr rd, input logic we);
    valid_i = 1'b1; in_unit = unit; in_data = d; in_rd = rd; in_rd_we = we;
  endtask

  initial begin
    rst_core = 1'b1; flush_req = 1'b0; in_data = '0; in_unit = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_rd_we = 1'b0;
    valid_i = 1'b0; out_ready = 4'b1111; wb_addr = '0; wb_en = 1'b0;
    in_unit3 = '0; valid3 = 1'b0;
    tick; tick;
    rst_core = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_ready", 64'(ready_o), 64'h1);
    check("rst_flush_ack", 64'(flush_ack), 64'h0);
    check("rst_err", 64'(err_o), 64'h0);
    check("rst_busy", 64'(dut.busy), 64'h0);

    // RAW hazard on x5, released one cycle after writeback
    beat(2'd0, 64'hA0A0, 5'd5, 1'b1);
    #1 check("raw_first_ready", 64'(ready_o), 64'h1);
    tick;
    check("raw_latency_valid", 64'(out_valid[0]), 64'h1);
    check("raw_latency_data", out_data[0 +: 64], 64'hA0A0);
    beat(2'd0, 64'hB0B0, 5'd0, 1'b0);
    in_use_rs1 = 1'b1; in_rs1 = 5'd5;
    #1 check("raw_stall", 64'(ready_o), 64'h0);
    tick;
    check("raw_stall_no_push", 64'(out_valid[0]), 64'h0);
    wb_en = 1'b1; wb_addr = 5'd5;
    #1 check("raw_no_bypass", 64'(ready_o), 64'h0);
    tick;
    wb_en = 1'b0;
    #1 check("raw_release", 64'(ready_o), 64'h1);
    tick;
    valid_i = 1'b0; in_use_rs1 = 1'b0;
    check("raw_second_data", out_data[0 +: 64], 64'hB0B0);
    tick;

    // x0 is never tracked
    beat(2'd2, 64'hC0C0, 5'd0, 1'b1);
    #1 check("x0_ready", 64'(ready_o), 64'h1);
    tick;
    check("x0_busy", 64'(dut.busy), 64'h0);
    beat(2'd2, 64'hD0D0, 5'd0, 1'b0);
    in_use_rs1 = 1'b1; in_rs1 = 5'd0;
    #1 check("x0_no_stall", 64'(ready_o), 64'h1);
    tick;
    valid_i = 1'b0; in_use_rs1 = 1'b0;
    check("x0_second_data", out_data[128 +: 64], 64'hD0D0);
    tick;

    // Backpressure on unit 1
    out_ready = 4'b1101;
    beat(2'd1, 64'h1111, 5'd0, 1'b0);
    #1 check("bp_p1_ready", 64'(ready_o), 64'h1);
    tick;
    beat(2'd1, 64'h2222, 5'd0, 1'b0);
    #1 check("bp_p2_ready", 64'(ready_o), 64'h1);
    tick;
    beat(2'd1, 64'h3333, 5'd0, 1'b0);
    #1 check("bp_p3_stall", 64'(ready_o), 64'h0);
    tick;
    check("bp_head_p1", out_data[64 +: 64], 64'h1111);
    out_ready = 4'b1111;
    #1 check("bp_full_pop_no_push", 64'(ready_o), 64'h0);
    tick;
    check("bp_head_p2", out_data[64 +: 64], 64'h2222);
    check("bp_p3_ready", 64'(ready_o), 64'h1);
    tick;
    valid_i = 1'b0;
    check("bp_head_p3", out_data[64 +: 64], 64'h3333);
    check("bp_valid_p3", 64'(out_valid[1]), 64'h1);
    tick;
    check("bp_drained", 64'(out_valid[1]), 64'h0);

    // Flush with queued entries and x7 busy
    out_ready = 4'b0000;
    beat(2'd3, 64'hE0E0, 5'd7, 1'b1);
    tick;
    beat(2'd3, 64'hF0F0, 5'd0, 1'b0);
    tick;
    valid_i = 1'b0; in_rd_we = 1'b0;
    in_use_rs2 = 1'b1; in_rs2 = 5'd7;
    #1 check("fl_queued", 64'(out_valid[3]), 64'h1);
    check("fl_busy7_hazard", 64'(ready_o), 64'h0);
    check("fl_busy7", 64'(dut.busy[7]), 64'h1);
    flush_req = 1'b1;
    #1 check("fl_req_ack_low", 64'(flush_ack), 64'h0);
    tick;
    flush_req = 1'b0;
    #1 check("fl_out_valid", 64'(out_valid), 64'h0);
    check("fl_busy", 64'(dut.busy), 64'h0);
    check("fl_ack_high", 64'(flush_ack), 64'h1);
    check("fl_ready_after", 64'(ready_o), 64'h1);
    tick;
    in_use_rs2 = 1'b0;
    check("fl_ack_pulse", 64'(flush_ack), 64'h0);

    // Illegal unit on a three-channel instance
    valid3 = 1'b1; in_unit3 = 2'd3; in_rd = 5'd11; in_rd_we = 1'b1; in_data = 64'h9999;
    #1 check("ill_ready", 64'(ready3), 64'h1);
    check("ill_err_before", 64'(err3), 64'h0);
    tick;
    valid3 = 1'b0; in_rd_we = 1'b0;
    check("ill_err_pulse", 64'(err3), 64'h1);
    check("ill_no_valid", 64'(out_valid3), 64'h0);
    check("ill_busy", 64'(dut3.busy), 64'h0);
    tick;
    check("ill_err_clear", 64'(err3), 64'h0);
    check("ill_still_no_valid", 64'(out_valid3), 64'h0);
    check("main_err_quiet", 64'(err_o), 64'h0);

    // Reset with a full FIFO and a busy register
    out_ready = 4'b0000;
    beat(2'd0, 64'h5151, 5'd9, 1'b1);
    tick;
    beat(2'd0, 64'h5252, 5'd0, 1'b0);
    tick;
    #1 check("rs_full", 64'(ready_o), 64'h0);
    rst_core = 1'b1; flush_req = 1'b1;
    tick;
    rst_core = 1'b0; flush_req = 1'b0; valid_i = 1'b0;
    #1 check("rs_out_valid", 64'(out_valid), 64'h0);
    check("rs_busy", 64'(dut.busy), 64'h0);
    check("rs_flush_ack", 64'(flush_ack), 64'h0);
    check("rs_err", 64'(err_o), 64'h0);
    tick;
    check("rs_quiet", 64'(out_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hsv_core_dispatch.md
HSV_CORE_DISPATCH -- requirements
Module: hsv_core_dispatch

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4, number of execution-unit output channels (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, entries per channel FIFO (power of two, >=2).
REQ-003 SHALL have parameter WIDTH, default 64, payload width in bits.
REQ-004 SHALL have ports:
- clk_core  in  1  core clock; one clock domain, all logic on its rising edge
- rst_core  in  1  synchronous active-high reset
- flush_req  in  1  pipeline flush request
- flush_ack  out  1  flush acknowledge
- in_data  in  WIDTH  instruction payload
- in_unit  in  $clog2(NUM_UNITS) (min 1)  target channel index
- in_rs1, in_rs2, in_rd  in  5 each  register addresses (reg_addr)
- in_use_rs1, in_use_rs2, in_rd_we  in  1 each  operand-read / dest-write qualifiers
- valid_i  in  1  input valid
- ready_o  out  1  input ready
- out_data  out  NUM_UNITS*WIDTH  per-channel head payload, channel k at bits [k*WIDTH +: WIDTH]
- out_valid  out  NUM_UNITS  per-channel valid
- out_ready  in  NUM_UNITS  per-channel ready
- wb_addr  in  5  writeback register address
- wb_en  in  1  writeback commit strobe
- err_o  out  1  one-cycle pulse on an accepted beat with illegal in_unit

Function
REQ-005 SHALL accept a beat when valid_i & ready_o; ready_o SHALL have no combinational path from out_ready or wb_en.
REQ-006 SHALL hold a 32-bit scoreboard busy[31:0]; busy[0] SHALL be constant 0.
REQ-007 SHALL define hazard = (in_use_rs1 & busy[in_rs1]) | (in_use_rs2 & busy[in_rs2]) | (in_rd_we & busy[in_rd]).
REQ-008 SHALL drive ready_o = ~flush_req & ~hazard & ~full[in_unit]; when in_unit >= NUM_UNITS, the full term SHALL be 0.
REQ-009 SHALL, on acceptance with in_rd_we & in_rd!=0, set busy[in_rd] at the next edge.
REQ-010 SHALL, on wb_en, clear busy[wb_addr] at the next edge; wb_en on a non-busy register SHALL be a no-op.
REQ-011 SHALL evaluate hazard against registered busy; a wb_en in cycle N unblocks the stalled beat in cycle N+1 (no bypass).
REQ-012 SHALL push an accepted beat into FIFO[in_unit]; it SHALL appear on out_data/out_valid of that channel one cycle later (latency 1).
REQ-013 SHALL keep each FIFO in program order, with out_valid[k] = (count[k] != 0) and out_data[k] = head entry.
REQ-014 SHALL pop FIFO[k] on out_valid[k] & out_ready[k].
REQ-015 SHALL wrap read/write pointers modulo DEPTH and keep count in $clog2(DEPTH)+1 bits.
REQ-016 SHALL treat full[k] = (count[k] == DEPTH); a full FIFO SHALL refuse a push even when popping the same cycle.
REQ-017 SHALL, when push and pop hit the same non-full, non-empty FIFO, leave count unchanged.
REQ-018 SHALL, for an accepted beat with in_unit >= NUM_UNITS, drop the payload, leave busy unchanged, and pulse err_o in the next cycle.
REQ-019 SHALL, while flush_req is high, empty all FIFOs and clear the scoreboard at the next edge.
REQ-020 SHALL, while flush_req is high, ignore wb_en and out_ready.
REQ-021 SHALL register flush_ack = flush_req delayed by one cycle.

Reset
REQ-022 SHALL, on rst_core high at a clock edge, clear all counts/pointers, busy, flush_ack and err_o.
REQ-023 SHALL drive out_valid = 0 and ready_o per REQ-008 with empty state in the first cycle after reset.
REQ-024 SHALL abandon any in-flight beat when reset is asserted mid-operation, with no output pulse afterward.

Structure
REQ-025 SHALL take reg_addr and reg_mask from hsv_core_pkg; a dispatch_fifo_ptr typedef and the x0 constant belong there.
REQ-026 SHALL instantiate one sub-module hsv_core_dispatch_fifo (WIDTH, DEPTH) per channel via generate.
REQ-027 SHALL keep scoreboard and ready logic in the top module, for 120-400 lines of RTL total.

Verification
REQ-028 RAW: accept rd=5 to unit 0; next beat rs1=5 -> ready_o=0 until one cycle after wb_en with wb_addr=5, then accepted.
REQ-029 Backpressure: DEPTH=2, out_ready[1]=0, three beats to unit 1 -> first two accepted, third stalls; raise out_ready[1] -> payloads drain in order.
REQ-030 Flush: two entries queued, busy[7]=1, flush_req for 1 cycle -> next cycle out_valid=0, busy=0, flush_ack=1 for one cycle.
REQ-031 x0: accept in_rd=0 with in_rd_we=1, then rs1=0 -> no stall, busy stays 0.
REQ-032 Illegal unit: NUM_UNITS=3, in_unit=3 -> accepted, err_o=1 for one cycle, all out_valid remain 0.
REQ-033 Reset mid-stream: rst_core asserted with full FIFOs -> next cycle all out_valid=0, busy=0, flush_ack=0.
